parity_tx_serializer: RTL and testbench

Serial transmit stage that sits directly downstream of the 8-bit parity generator. Accepts a data byte plus its parity bit through a valid/ready handshake, then shifts out a framed serial word on one line, LSB first: start bit, data bits, parity bit, stop bit. It turns the parity generator's combinational result into a transmitted, checkable bit stream for the link receiver.

---
 rtl/parity_link_pkg.sv | 21 ++
 rtl/parity_tx_serializer_if.sv | 12 +
 rtl/parity_tx_serializer_bit_timer.sv | 25 ++
 rtl/parity_tx_serializer.sv | 110 +++++++++++
 tb/tb_parity_tx_serializer.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/parity_link_pkg.sv
// Shared types and constants for the parity link transmit path.
// frame_len gives the cycle count of one serial frame from start bit through stop bit.
package parity_link_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    function automatic int frame_len(input int data_w, input int clks_per_bit);
        return (data_w + 3) * clks_per_bit;
    endfunction

endpackage

// File: rtl/parity_tx_serializer_if.sv
// Valid/ready word handshake between the parity generator and the serializer.
interface parity_tx_serializer_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_par;
    logic              in_ready;

    modport master (output in_valid, output in_data, output in_par, input in_ready);
    modport slave  (input in_valid, input in_data, input in_par, output in_ready);
endinterface

// File: rtl/parity_tx_serializer_bit_timer.sv
// Baud counter: counts 0..CLKS_PER_BIT-1 and ticks on the last cycle of each serial bit.
// Held at zero while clear is high so every frame starts bit-aligned.
module bit_timer #(
    parameter int  CLKS_PER_BIT = 4,
    localparam int CW           = $clog2(CLKS_PER_BIT) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    output logic          tick,
    output logic [CW-1:0] count
);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    assign tick = !clear && (count == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (clear || tick)
            count <= '0;
        else
            count <= count + 1'b1;
    end
endmodule

// File: rtl/parity_tx_serializer.sv
// Framed serial transmitter: start bit, DATA_W data bits LSB first, parity bit, stop bit.
// tx_out and frame_done are registered from the next-state values, so they line up with state.
//
//   state  | meaning
//   IDLE   | line high, ready for a word
//   START  | start bit (low) for one bit time
//   DATA   | shifting data bits out LSB first
//   PARITY | parity bit (in_par, optionally inverted)
//   STOP   | stop bit (high); frame_done on its last cycle
module parity_tx_serializer
    import parity_link_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter bit ODD_PARITY   = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    parity_tx_serializer_if.slave up,
    output logic                  tx_out,
    output logic                  busy,
    output logic                  frame_done
);
    localparam int CW = $clog2(CLKS_PER_BIT) + 1;
    localparam int BW = $clog2(DATA_W) + 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);
    localparam logic [CW-1:0] PRE_LAST = CW'((CLKS_PER_BIT >= 2) ? CLKS_PER_BIT - 2 : 0);

    tx_state_t         state, state_next;
    logic [DATA_W-1:0] shreg, shreg_next;
    logic              par_bit, par_bit_next;
    logic [BW-1:0]     bit_cnt, bit_cnt_next;
    logic              tx_next, done_next;
    logic              tick, accept;
    logic [CW-1:0]     baud_cnt;

    bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (state == IDLE),
        .tick  (tick),
        .count (baud_cnt)
    );

    assign accept      = up.in_valid && (state == IDLE);
    assign up.in_ready = (state == IDLE);
    assign busy        = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (up.in_valid) state_next = START;
            START:   if (tick) state_next = DATA;
            DATA:    if (tick && bit_cnt == LAST_BIT) state_next = PARITY;
            PARITY:  if (tick) state_next = STOP;
            STOP:    if (tick) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        shreg_next   = shreg;
        par_bit_next = par_bit;
        bit_cnt_next = bit_cnt;
        tx_next      = LINE_IDLE;
        if (accept) begin
            shreg_next   = up.in_data;
            par_bit_next = up.in_par ^ ODD_PARITY;
        end
        if (state == START && tick)
            bit_cnt_next = '0;
        if (state == DATA && tick) begin
            shreg_next   = shreg >> 1;
            bit_cnt_next = bit_cnt + 1'b1;
        end
        case (state_next)
            START:   tx_next = START_BIT;
            DATA:    tx_next = shreg_next[0];
            PARITY:  tx_next = par_bit_next;
            STOP:    tx_next = STOP_BIT;
            default: tx_next = LINE_IDLE;
        endcase
        // The cycle about to start is the last stop cycle.
        done_next = (state_next == STOP) &&
                    ((CLKS_PER_BIT == 1) || (state == STOP && baud_cnt == PRE_LAST));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg      <= '0;
            par_bit    <= 1'b0;
            bit_cnt    <= '0;
            tx_out     <= LINE_IDLE;
            frame_done <= 1'b0;
        end else begin
            shreg      <= shreg_next;
            par_bit    <= par_bit_next;
            bit_cnt    <= bit_cnt_next;
            tx_out     <= tx_next;
            frame_done <= done_next;
        end
    end
endmodule

// File: tb/tb_parity_tx_serializer.sv
// Bench for parity_tx_serializer: three instances (defaults, odd parity, 5-bit/1-clock-per-bit)
// checked cycle by cycle against a frame model built from the framing rules.
`timescale 1ns/1ps
module tb_parity_tx_serializer;
    import parity_link_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_par = 1'b0;
    int          sel = 0;

    always #5 clk = ~clk;

    parity_tx_serializer_if #(.DATA_W(8)) if_a ();
    parity_tx_serializer_if #(.DATA_W(8)) if_b ();
    parity_tx_serializer_if #(.DATA_W(5)) if_c ();

    assign if_a.in_valid = in_valid && (sel == 0);
    assign if_a.in_data  = in_data[7:0];
    assign if_a.in_par   = in_par;
    assign if_b.in_valid = in_valid && (sel == 1);
    assign if_b.in_data  = in_data[7:0];
    assign if_b.in_par   = in_par;
    assign if_c.in_valid = in_valid && (sel == 2);
    assign if_c.in_data  = in_data[4:0];
    assign if_c.in_par   = in_par;

    logic tx_a, busy_a, done_a, tx_b, busy_b, done_b, tx_c, busy_c, done_c;

    parity_tx_serializer #(.DATA_W(8), .CLKS_PER_BIT(4), .ODD_PARITY(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .up(if_a), .tx_out(tx_a), .busy(busy_a), .frame_done(done_a));
    parity_tx_serializer #(.DATA_W(8), .CLKS_PER_BIT(4), .ODD_PARITY(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .up(if_b), .tx_out(tx_b), .busy(busy_b), .frame_done(done_b));
    parity_tx_serializer #(.DATA_W(5), .CLKS_PER_BIT(1), .ODD_PARITY(1'b0)) dut_c (
        .clk(clk), .rst_n(rst_n), .up(if_c), .tx_out(tx_c), .busy(busy_c), .frame_done(done_c));

    logic tx_s, ready_s, busy_s, done_s;
    always_comb begin
        case (sel)
            1:       begin tx_s = tx_b; ready_s = if_b.in_ready; busy_s = busy_b; done_s = done_b; end
            2:       begin tx_s = tx_c; ready_s = if_c.in_ready; busy_s = busy_c; done_s = done_c; end
            default: begin tx_s = tx_a; ready_s = if_a.in_ready; busy_s = busy_a; done_s = done_a; end
        endcase
    end

    function automatic int w_of(input int s); return (s == 2) ? 5 : 8; endfunction
    function automatic int c_of(input int s); return (s == 2) ? 1 : 4; endfunction
    function automatic logic odd_of(input int s); return (s == 1); endfunction

    int n_checks = 0;
    int n_fail = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endfunction

    // Expected line value per cycle, from the first start-bit cycle through the last stop cycle.
    logic exp_q[$];
    task automatic build_exp(input int s, input logic [15:0] d, input logic pbit);
        logic fb[$];
        exp_q.delete();
        fb.push_back(START_BIT);
        for (int k = 0; k < w_of(s); k++) fb.push_back(d[k]);
        fb.push_back(pbit);
        fb.push_back(STOP_BIT);
        foreach (fb[i]) repeat (c_of(s)) exp_q.push_back(fb[i]);
    endtask

    task automatic run_frame(input logic [15:0] d, input logic p, input logic pbit, input bit hold,
                             input logic [15:0] nd, input logic np, input string tag);
        int w = 0;
        int len;
        build_exp(sel, d, pbit);
        len = exp_q.size();
        chk($sformatf("%s frame_len", tag), len, frame_len(w_of(sel), c_of(sel)));
        in_valid = 1'b1;
        in_data  = d;
        in_par   = p;
        while (!ready_s && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk($sformatf("%s accept wait", tag), w, 0);
        if (w >= 200) begin
            in_valid = 1'b0;
            return;
        end
        @(negedge clk);
        if (hold) begin
            in_data = nd;
            in_par  = np;
        end else begin
            in_valid = 1'b0;
        end
        for (int i = 0; i < len; i++) begin
            chk($sformatf("%s tx[%0d]", tag, i), tx_s, exp_q[i]);
            chk($sformatf("%s done[%0d]", tag, i), done_s, (i == len - 1));
            chk($sformatf("%s busy[%0d]", tag, i), busy_s, 1);
            chk($sformatf("%s ready[%0d]", tag, i), ready_s, 0);
            @(negedge clk);
        end
        chk($sformatf("%s idle tx", tag), tx_s, 1);
        chk($sformatf("%s idle ready", tag), ready_s, 1);
        chk($sformatf("%s idle busy", tag), busy_s, 0);
        chk($sformatf("%s idle done", tag), done_s, 0);
    endtask

    typedef struct {
        int          s;
        logic [15:0] d;
        logic        p;
        logic        exp_pbit;
        bit          hold;
        logic [15:0] nd;
        logic        np;
    } vec_t;

    vec_t vecs[10];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{0, 16'h00A5, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0};
        vecs[1] = '{1, 16'h0001, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0};
        vecs[2] = '{0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h00FF, 1'b0};
        vecs[3] = '{0, 16'h00FF, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0};
        vecs[4] = '{0, 16'h0012, 1'b0, 1'b0, 1'b1, 16'h003C, 1'b0};
        vecs[5] = '{0, 16'h003C, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0};
        vecs[6] = '{2, 16'h0015, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0};
        vecs[7] = '{2, 16'h001F, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b0};
        vecs[8] = '{2, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0};
        vecs[9] = '{1, 16'h00FF, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0};

        // Reset held with in_valid high: nothing may start.
        #1 rst_n = 1'b0;
        in_valid = 1'b1;
        in_data  = 16'h00A5;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("rst tx[%0d]", i), tx_s, 1);
            chk($sformatf("rst ready[%0d]", i), ready_s, 1);
            chk($sformatf("rst busy[%0d]", i), busy_s, 0);
            chk($sformatf("rst done[%0d]", i), done_s, 0);
        end
        in_valid = 1'b0;
        rst_n    = 1'b1;
        repeat (2) @(negedge clk);
        chk("post-rst tx", tx_s, 1);
        chk("post-rst busy", busy_s, 0);

        foreach (vecs[v]) begin
            sel = vecs[v].s;
            run_frame(vecs[v].d, vecs[v].p, vecs[v].exp_pbit, vecs[v].hold,
                      vecs[v].nd, vecs[v].np, $sformatf("vec%0d", v));
        end

        // Reset during data bit 3 of a frame.
        sel      = 0;
        in_valid = 1'b1;
        in_data  = 16'h0000;
        in_par   = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (17) @(negedge clk);
        chk("midrst bit3 tx", tx_s, 0);
        chk("midrst bit3 busy", busy_s, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst tx", tx_s, 1);
        chk("midrst ready", ready_s, 1);
        chk("midrst busy", busy_s, 0);
        chk("midrst done", done_s, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("after midrst tx", tx_s, 1);
        chk("after midrst busy", busy_s, 0);
        run_frame(16'h005A, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, "rst5A");

        // Random words; in_par is arbitrary because it is transmitted as given.
        for (int r = 0; r < 30; r++) begin
            logic [15:0] d;
            logic        p;
            sel = int'($urandom_range(0, 2));
            d   = 16'($urandom);
            p   = 1'($urandom_range(0, 1));
            run_frame(d, p, p ^ odd_of(sel), 1'b0, 16'h0000, 1'b0, $sformatf("rnd%0d", r));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
